// File: rtl/hist_centroid_if.sv
// Sample/start/result bus for hist_centroid.
// The leds signal exists only when HIST_CENTROID_LEDS_EN is defined.
interface hist_centroid_if #(
  parameter int unsigned NCOL  = 80,
  parameter int unsigned HBITS = 6,
  parameter int unsigned NLED  = 8
);
  localparam int unsigned CW = $clog2(NCOL);
  localparam int unsigned AW = HBITS + CW;

  logic             in_valid;
  logic [CW-1:0]    col_idx;
  logic [HBITS-1:0] col_val;
  logic             start;
  logic             busy;
  logic             done;
  logic [CW-1:0]    centroid;
  logic [AW-1:0]    area;
  logic             empty;
`ifdef HIST_CENTROID_LEDS_EN
  logic [NLED-1:0]  leds;
`endif

  modport master (
    output in_valid, col_idx, col_val, start,
    input  busy, done, centroid, area, empty
`ifdef HIST_CENTROID_LEDS_EN
    , input leds
`endif
  );

  modport slave (
    input  in_valid, col_idx, col_val, start,
    output busy, done, centroid, area, empty
`ifdef HIST_CENTROID_LEDS_EN
    , output leds
`endif
  );
endinterface

// File: rtl/hist_centroid.sv
// Per-column running-max histogram with centroid = floor(sum(v*k)/sum(v)).
// Optional one-hot LED bar output enabled by macro HIST_CENTROID_LEDS_EN.
module hist_centroid #(
  parameter int unsigned NCOL  = 80,
  parameter int unsigned HBITS = 6,
  parameter int unsigned NLED  = 8
) (
  input logic           clk,
  input logic           rst,
  hist_centroid_if.slave bus
);
  localparam int unsigned CW = $clog2(NCOL);
  localparam int unsigned AW = HBITS + CW;
  localparam int unsigned MW = HBITS + 2 * CW;

  typedef enum logic [1:0] {IDLE, ACCUM, DIV, OUT} state_t;

  state_t           r_state;
  logic [HBITS-1:0] r_cap  [NCOL];
  logic [HBITS-1:0] r_calc [NCOL];
  logic [CW-1:0]    r_k;
  logic [AW-1:0]    r_acc_area;
  logic [MW-1:0]    r_rem;
  logic [CW-1:0]    r_quot;
  logic             r_busy;
  logic             r_done;
  logic [CW-1:0]    r_centroid;
  logic [AW-1:0]    r_area;
  logic             r_empty;
`ifdef HIST_CENTROID_LEDS_EN
  logic [NLED-1:0]  r_leds;
  int unsigned      w_led_pos;
`endif

  logic             w_start_go;
  logic             w_wr;
  logic [HBITS-1:0] w_term;
  logic [AW-1:0]    w_area_nxt;
  logic [MW-1:0]    w_mom_nxt;
  logic [MW-1:0]    w_div_sub;
  logic             w_ge;
  logic [CW-1:0]    w_q_nxt;

  assign w_start_go = (r_state == IDLE) && bus.start;
  assign w_wr       = bus.in_valid && (32'(bus.col_idx) < NCOL);

  // r_k is the column index in ACCUM and the quotient bit index in DIV
  always_comb begin
    w_term     = r_calc[r_k];
    w_area_nxt = r_acc_area + AW'(w_term);
    w_mom_nxt  = r_rem + MW'(w_term) * MW'(r_k);
    w_div_sub  = MW'(r_acc_area) << r_k;
    w_ge       = (r_rem >= w_div_sub);
    w_q_nxt    = r_quot | (w_ge ? (CW'(1) << r_k) : '0);
`ifdef HIST_CENTROID_LEDS_EN
    w_led_pos  = (32'(w_q_nxt) * NLED) / NCOL;
`endif
  end

  // Capture bank is cleared on start; a same-cycle sample lands in the fresh frame
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NCOL); i++) begin
        r_cap[i]  <= '0;
        r_calc[i] <= '0;
      end
    end else begin
      if (w_start_go) begin
        for (int i = 0; i < int'(NCOL); i++) begin
          r_calc[i] <= r_cap[i];
          r_cap[i]  <= '0;
        end
      end
      if (w_wr && (bus.col_val > (w_start_go ? HBITS'(0) : r_cap[bus.col_idx])))
        r_cap[bus.col_idx] <= bus.col_val;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_k        <= '0;
      r_acc_area <= '0;
      r_rem      <= '0;
      r_quot     <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_centroid <= '0;
      r_area     <= '0;
      r_empty    <= 1'b1;
`ifdef HIST_CENTROID_LEDS_EN
      r_leds     <= '0;
`endif
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_state    <= ACCUM;
            r_busy     <= 1'b1;
            r_k        <= '0;
            r_acc_area <= '0;
            r_rem      <= '0;
          end
        end
        ACCUM: begin
          r_acc_area <= w_area_nxt;
          r_rem      <= w_mom_nxt;
          if (r_k == CW'(NCOL - 1)) begin
            r_quot <= '0;
            r_k    <= CW'(CW - 1);
            if (w_area_nxt == '0) begin
              // Empty frame skips the divider entirely
              r_state    <= OUT;
              r_done     <= 1'b1;
              r_centroid <= '0;
              r_area     <= '0;
              r_empty    <= 1'b1;
`ifdef HIST_CENTROID_LEDS_EN
              r_leds     <= '0;
`endif
            end else begin
              r_state <= DIV;
            end
          end else begin
            r_k <= r_k + CW'(1);
          end
        end
        DIV: begin
          if (w_ge) r_rem <= r_rem - w_div_sub;
          r_quot <= w_q_nxt;
          if (r_k == '0) begin
            r_state    <= OUT;
            r_done     <= 1'b1;
            r_centroid <= w_q_nxt;
            r_area     <= r_acc_area;
            r_empty    <= 1'b0;
`ifdef HIST_CENTROID_LEDS_EN
            r_leds     <= NLED'(1) << (NLED - 1 - w_led_pos);
`endif
          end else begin
            r_k <= r_k - CW'(1);
          end
        end
        OUT: begin
          r_state <= IDLE;
          r_busy  <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.done     = r_done;
  assign bus.centroid = r_centroid;
  assign bus.area     = r_area;
  assign bus.empty    = r_empty;
`ifdef HIST_CENTROID_LEDS_EN
  assign bus.leds     = r_leds;
`endif
endmodule

// File: tb/tb_hist_centroid.sv
// Randomized plus directed bench for hist_centroid against a frame-level model.
module tb_hist_centroid;
  localparam int unsigned NCOL  = 80;
  localparam int unsigned HBITS = 6;
  localparam int unsigned NLED  = 8;
  localparam int unsigned CW    = $clog2(NCOL);

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_errors = 0;

  hist_centroid_if #(.NCOL(NCOL), .HBITS(HBITS), .NLED(NLED)) bus ();

  hist_centroid #(.NCOL(NCOL), .HBITS(HBITS), .NLED(NLED)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Frame-level model: running-max bank, snapshot on accepted start, results by plain arithmetic
  int m_cap [NCOL];
  bit m_active;
  int m_t, m_done;
  int p_cent, p_area, p_empty, p_leds;
  int e_cent, e_area, e_empty, e_leds;

  task automatic model_reset();
    foreach (m_cap[i]) m_cap[i] = 0;
    m_active = 0; m_t = 0; m_done = 0;
    e_cent = 0; e_area = 0; e_empty = 1; e_leds = 0;
  endtask

  initial model_reset();

  always @(negedge clk) begin
    bit idle;
    int area, mom;
    if (rst) model_reset();
    if (m_active && cyc == m_done) begin
      e_cent = p_cent; e_area = p_area; e_empty = p_empty; e_leds = p_leds;
    end
    chk("busy", bus.busy, (m_active && cyc > m_t && cyc <= m_done) ? 1 : 0);
    chk("done", bus.done, (m_active && cyc == m_done) ? 1 : 0);
    chk("centroid", bus.centroid, e_cent);
    chk("area", bus.area, e_area);
    chk("empty", bus.empty, e_empty);
`ifdef HIST_CENTROID_LEDS_EN
    chk("leds", bus.leds, e_leds);
`endif
    if (!rst) begin
      idle = !m_active || cyc > m_done;
      if (bus.start && idle) begin
        area = 0; mom = 0;
        for (int k = 0; k < int'(NCOL); k++) begin
          area += m_cap[k];
          mom  += m_cap[k] * k;
          m_cap[k] = 0;
        end
        m_active = 1;
        m_t      = cyc;
        m_done   = cyc + int'(NCOL) + ((area != 0) ? int'(CW) : 0) + 1;
        p_area   = area;
        p_empty  = (area == 0) ? 1 : 0;
        p_cent   = (area == 0) ? 0 : mom / area;
        p_leds   = (area == 0) ? 0 : (1 << (int'(NLED) - 1 - p_cent * int'(NLED) / int'(NCOL)));
      end
      if (bus.in_valid && int'(bus.col_idx) < int'(NCOL) && int'(bus.col_val) > m_cap[bus.col_idx])
        m_cap[bus.col_idx] = int'(bus.col_val);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input int idx, input int val);
    bus.in_valid = 1'b1;
    bus.col_idx  = CW'(idx);
    bus.col_val  = HBITS'(val);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_start(input bit with_s, input int idx, input int val, output int t);
    bus.start    = 1'b1;
    bus.in_valid = with_s;
    bus.col_idx  = CW'(idx);
    bus.col_val  = HBITS'(val);
    t = cyc;
    tick();
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_done(input int budget, output bit found, output int at);
    found = 0;
    at    = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.done) begin
        found = 1;
        at    = cyc;
        break;
      end
    end
    tick();
  endtask

  task automatic frame(input string nm, input int lat, input int cent, input int area, input int empty);
    int  t, at;
    bit  f;
    do_start(1'b0, 0, 0, t);
    wait_done(200, f, at);
    chk({nm, "_seen"}, f, 1);
    chk({nm, "_lat"}, at - t, lat);
    chk({nm, "_cent"}, bus.centroid, cent);
    chk({nm, "_area"}, bus.area, area);
    chk({nm, "_empty"}, bus.empty, empty);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  t, at;
    bit  f;
    bus.in_valid = 1'b0;
    bus.col_idx  = '0;
    bus.col_val  = '0;
    bus.start    = 1'b0;
    repeat (3) tick();
    chk("rst_area", bus.area, 0);
    chk("rst_empty", bus.empty, 1);
    rst = 1'b0;
    tick();

    sample(40, 10);
    frame("single", 88, 40, 10, 0);
`ifdef HIST_CENTROID_LEDS_EN
    chk("single_leds", bus.leds, 8);
`endif

    sample(10, 5); sample(30, 5);
    frame("pair", 88, 20, 10, 0);

    sample(5, 3); sample(5, 9); sample(5, 2);
    frame("runmax", 88, 5, 9, 0);

    sample(79, 63); sample(100, 50);
    frame("edge79", 88, 79, 63, 0);

    frame("empty", 81, 0, 0, 1);
`ifdef HIST_CENTROID_LEDS_EN
    chk("empty_leds", bus.leds, 0);
`endif

    // Restart ignored while busy; start-cycle sample goes to the next frame
    sample(40, 10);
    do_start(1'b1, 2, 7, t);
    repeat (19) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done(200, f, at);
    chk("overlap_lat", at - t, 88);
    chk("overlap_area", bus.area, 10);
    wait_done(100, f, at);
    chk("overlap_no_2nd", f, 0);
    frame("nextframe", 88, 2, 7, 0);

    // Reset during DIV aborts the frame
    sample(40, 10);
    do_start(1'b0, 0, 0, t);
    while (cyc < t + 83) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wait_done(120, f, at);
    chk("abort_no_done", f, 0);
    chk("abort_area", bus.area, 0);
    chk("abort_empty", bus.empty, 1);
    sample(20, 4);
    frame("after_rst", 88, 20, 4, 0);

    for (int i = 0; i < 4000; i++) begin
      bus.in_valid = 1'($urandom_range(0, 1));
      bus.col_idx  = CW'($urandom);
      bus.col_val  = HBITS'($urandom);
      bus.start    = ($urandom_range(0, 59) == 0);
      tick();
    end
    bus.in_valid = 1'b0;
    bus.start    = 1'b0;
    repeat (100) tick();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
